// File: rtl/enc_serializer.sv
// enc_serializer
// Splits 141-bit Hsiao DEC codewords (data [126:0], parity [140:127]) into
// NBEATS = ceil(141/W) beats of W bits, sent LSB first. The last beat is
// zero padded. Codeword bits are passed through unchanged.
//
// A second (pending) register lets the next codeword be accepted while the
// current one is still being sent, so words stream without gaps.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_cw      141-bit codeword
//   in_valid   in_cw valid this cycle
//   in_ready   block can accept in_cw (pending slot empty)
//   out_data   current W-bit beat (0 when idle)
//   out_valid  out_data valid
//   out_ready  downstream accepts the beat
//   out_last   current beat is the final beat of a codeword
//   busy       a codeword is held, in progress or pending
module enc_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [140:0] in_cw,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    localparam int CW_W   = 141;
    localparam int NBEATS = (CW_W + W - 1) / W;
    localparam int PADW   = NBEATS * W;
    localparam int BCW    = $clog2(NBEATS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

    logic [CW_W-1:0] cur;
    logic [CW_W-1:0] nxt;
    logic            cur_valid;
    logic            nxt_valid;
    logic [BCW-1:0]  beat_cnt;

    logic            in_hs;
    logic            out_hs;
    logic            last_hs;
    logic            load_cur;
    logic            load_nxt;
    logic            promote;
    logic [PADW-1:0] padded;
    logic [PADW-1:0] shifted;

    // Handshake decode; in_ready depends on registered state only
    assign in_ready = !nxt_valid;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = cur_valid && out_ready;
    assign last_hs  = out_hs && out_last;

    // A new word goes straight into cur when cur is free, or when cur is
    // finishing its last beat this cycle with nothing pending behind it.
    assign load_cur = in_hs && (!cur_valid || (last_hs && !nxt_valid));
    assign load_nxt = in_hs && !load_cur;
    assign promote  = last_hs && nxt_valid;

    // Control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (out_hs) begin
                beat_cnt <= out_last ? '0 : beat_cnt + BCW'(1);
            end

            if (load_cur) begin
                cur_valid <= 1'b1;
            end else if (last_hs && !nxt_valid) begin
                cur_valid <= 1'b0;
            end

            if (load_nxt) begin
                nxt_valid <= 1'b1;
            end else if (promote) begin
                nxt_valid <= 1'b0;
            end
        end
    end

    // Codeword storage; no reset, contents are qualified by the valid flags
    always_ff @(posedge clk) begin
        if (load_cur) begin
            cur <= in_cw;
        end else if (promote) begin
            cur <= nxt;
        end

        if (load_nxt) begin
            nxt <= in_cw;
        end
    end

    // Beat select: zero-extend to a whole number of beats, then shift the
    // current beat down to the bottom.
    assign padded   = PADW'(cur);
    assign shifted  = padded >> (int'(beat_cnt) * W);

    assign out_valid = cur_valid;
    assign out_last  = cur_valid && (beat_cnt == LAST_BEAT);
    assign out_data  = cur_valid ? shifted[W-1:0] : '0;
    assign busy      = cur_valid || nxt_valid;

endmodule

// File: doc/enc_serializer.md
ENC_SERIALIZER -- requirements
Module: enc_serializer

Interface
REQ-001 Parameter: W, default 8, output beat width in bits; legal values 1, 2, 4, 8, 16, 32.
REQ-002 Derived constant: NBEATS = ceil(141/W); 18 for W=8.
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_cw  input  141  codeword from the Hsiao DEC encoder: data in [126:0], parity in [140:127].
REQ-006 in_valid  input  1  in_cw is valid this cycle.
REQ-007 in_ready  output  1  block can accept in_cw this cycle.
REQ-008 out_data  output  W  current beat.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  downstream accepts the beat this cycle.
REQ-011 out_last  output  1  current beat is beat NBEATS-1 of a codeword.
REQ-012 busy  output  1  any codeword is held, in progress or pending.

Function
REQ-013 Storage: one active register (cur, 141 bits, with cur_valid) and one pending register (nxt, 141 bits, with nxt_valid); beat counter beat_cnt, range 0..NBEATS-1.
REQ-014 An input handshake occurs when in_valid=1 and in_ready=1 in the same cycle; an output handshake occurs when out_valid=1 and out_ready=1 in the same cycle.
REQ-015 in_ready = !nxt_valid, combinational from registered state only, with no path from in_valid or out_ready.
REQ-016 On an input handshake, in_cw loads into cur if cur_valid=0 or (an output handshake on the last beat occurs and nxt_valid=0); otherwise it loads into nxt.
REQ-017 On an output handshake on the last beat with nxt_valid=1, cur loads from nxt, nxt_valid clears, and beat_cnt becomes 0.
REQ-018 On an output handshake on the last beat with nxt_valid=0 and no simultaneous input handshake, cur_valid clears.
REQ-019 out_valid = cur_valid, from registered state only.
REQ-020 Latency: out_valid asserts the cycle after the input handshake that loads cur.
REQ-021 Throughput: with out_ready held at 1 and input always available, consecutive codewords stream with no idle cycle between the last beat of one and beat 0 of the next.
REQ-022 Beat k (k = beat_cnt) carries out_data[j] = cur[k*W + j] for k*W + j <= 140, and 0 otherwise, so transmission is LSB first with zero padding in the last beat.
REQ-023 beat_cnt increments on each non-last output handshake, resets to 0 on a last-beat output handshake, and holds otherwise.
REQ-024 out_last = cur_valid && (beat_cnt == NBEATS-1).
REQ-025 While out_valid=1 and out_ready=0, out_data, out_last and beat_cnt hold stable.
REQ-026 busy = cur_valid || nxt_valid.
REQ-027 The block performs no parity check or modification of codeword contents; bits pass through unaltered.
REQ-028 An in_valid received while in_ready=0 is ignored and does not alter state.

Reset
REQ-029 rst_n=0 immediately clears cur_valid, nxt_valid and beat_cnt, without waiting for a clock edge.
REQ-030 Output values during reset: out_valid=0, out_last=0, busy=0, in_ready=1, out_data=0.
REQ-031 Reset during a transfer discards the partial codeword and any pending codeword; the first output after release is beat 0 of a newly accepted codeword.
REQ-032 cur and nxt data registers need no reset, but out_data SHALL be gated to 0 while cur_valid=0.

Verification
REQ-033 W=8, single codeword cw = 141'h1_5A5A...A5 (alternating pattern), out_ready=1 -> 18 beats; beat 0 = cw[7:0]; beat 17 = {3'b000, cw[140:136]} with out_last=1; busy drops the cycle after beat 17.
REQ-034 Three codewords offered back-to-back with out_ready=1 -> 54 consecutive valid beats with no gap; in_ready low while nxt is full; 3 out_last pulses, exactly 18 cycles apart.
REQ-035 Random out_ready backpressure (50%) over 100 random codewords -> reassembled words match the inputs bit-exactly, and out_data is stable whenever stalled.
REQ-036 Simultaneous last-beat output handshake and input handshake with nxt empty -> new word is in cur next cycle with beat_cnt=0 and no bubble.
REQ-037 rst_n pulled low asynchronously at beat 9 with nxt full -> out_valid=0 and in_ready=1 before the next edge; after release, a new codeword starts at beat 0.
REQ-038 W=32 -> NBEATS=5, and the last beat = {19'b0, cw[140:128]}.
